// File: rtl/text_buf_pkg.sv
// Shared definitions for the 80x60 character-cell text buffer: geometry,
// fill character and the write-arbiter state encoding.
package text_buf_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 60;
    localparam int ADDR_W = 13;
    localparam int CELLS  = COLS * ROWS;

    localparam logic [7:0]        FILL_CHAR = 8'h20;
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } wr_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // One extra bit so the comparison stays correct even if CELLS == 2**ADDR_W.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (ADDR_W+1)'(addr) < (ADDR_W+1)'(CELLS);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; the last-grant register only moves when a
// grant is actually issued, so idle cycles never shift priority.
module rr_arb2
    import text_buf_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    port_e last_q;
    port_e last_d;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        gnt_a  = 1'b0;
        gnt_b  = 1'b0;
        last_d = last_q;
        if (en) begin
            gnt_a = req_a && (!req_b || (last_q == PORT_B));
            gnt_b = req_b && (!req_a || (last_q == PORT_A));
        end
        if (gnt_a) begin
            last_d = PORT_A;
        end else if (gnt_b) begin
            last_d = PORT_B;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/text_wr_arbiter.sv
// Single write port of the text buffer: round-robin between the UART and
// overlay writers, range-checks addresses, and runs a full-screen clear.
module text_wr_arbiter
    import text_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              addr_err
);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              clr_busy_q, clr_busy_d;
    logic              clr_done_q, clr_done_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              addr_err_q, addr_err_d;

    logic              arb_active;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_data;

    // clr_busy stays high through the final fill write, so requesters are
    // held off until it falls.
    assign arb_active = (state_q == ARB) && !clr_busy_q;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .en    (arb_active),
        .req_a (a_valid),
        .req_b (b_valid),
        .gnt_a (a_ready),
        .gnt_b (b_ready)
    );

    assign xfer     = a_ready || b_ready;
    assign sel_addr = a_ready ? a_addr : b_addr;
    assign sel_data = a_ready ? a_data : b_data;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done_d = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        addr_err_d = 1'b0;

        unique case (state_q)
            ARB: begin
                if (xfer) begin
                    if (in_range(sel_addr)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_addr;
                        wr_data_d = sel_data;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
                // A transfer in the same cycle still completes; its write
                // lands before the first fill write.
                if (arb_active && clr_req) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = FILL_CHAR;
                if (clr_cnt_q == LAST_CELL) begin
                    clr_done_d = 1'b1;
                    clr_cnt_d  = '0;
                    state_d    = ARB;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase

        clr_busy_d = (state_d == CLEAR) || (state_q == CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign addr_err = addr_err_q;

endmodule
